// File: rtl/fifo_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ram_ctrl
// Purpose  : Initiator-side FIFO controller for a dual-address RAM. Turns
//            push/pop requests into RAM write/read commands. Keeps the
//            pointers, the occupancy count, the status flags and a sticky
//            overflow/underflow error.
// Ports    : clk, reset        - clock, asynchronous active-high reset
//            push, push_data   - enqueue request and its data
//            pop               - dequeue request
//            ram_rdata         - RAM data_out, valid one cycle after a read
//            addrw, addrr      - RAM write / read addresses (wr_ptr / rd_ptr)
//            rw                - RAM command {read_en, write_en}
//            data_in           - RAM write data (push_data)
//            pop_data, valid   - dequeued data and its qualifier
//            count             - occupancy 0..2^AW
//            full, empty, almost_full, almost_empty, error - status
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ram_ctrl #(
    parameter int AW           = 3,
    parameter int DW           = 4,
    parameter int ALMOST_FULL  = 6,
    parameter int ALMOST_EMPTY = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic [DW-1:0] ram_rdata,
    output logic [AW-1:0] addrw,
    output logic [AW-1:0] addrr,
    output logic [1:0]    rw,
    output logic [DW-1:0] data_in,
    output logic [DW-1:0] pop_data,
    output logic          valid,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          error
);

    localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] AF_C    = (AW+1)'(ALMOST_FULL);
    localparam logic [AW:0] AE_C    = (AW+1)'(ALMOST_EMPTY);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic          valid_q;
    logic          error_q;
    logic          push_ok;
    logic          pop_ok;

    // Flags come straight from the registered count; no look-ahead.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);

    // Gating by full/empty also keeps a full-FIFO push+pop from touching the
    // same RAM address twice in one cycle: only the pop goes through.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    assign rw      = {pop_ok, push_ok};
    assign addrw   = wr_ptr;
    assign addrr   = rd_ptr;
    assign data_in = push_data;

    assign count    = count_q;
    assign valid    = valid_q;
    assign error    = error_q;
    assign pop_data = valid_q ? ram_rdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            // Pointers wrap naturally at 2^AW.
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            // RAM read data arrives one cycle after the read command.
            valid_q <= pop_ok;
            // Any rejected request latches the error until reset.
            if ((push & full) | (pop & empty)) begin
                error_q <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_ram_ctrl
// Purpose  : Self-checking bench for fifo_ram_ctrl with a behavioural
//            dual-address RAM (synchronous read, one-cycle latency) and a
//            queue-based FIFO reference model / scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_ram_ctrl;

    localparam int AW    = 3;
    localparam int DW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          reset;
    logic          push;
    logic [DW-1:0] push_data;
    logic          pop;
    logic [DW-1:0] ram_rdata;
    logic [AW-1:0] addrw;
    logic [AW-1:0] addrr;
    logic [1:0]    rw;
    logic [DW-1:0] data_in;
    logic [DW-1:0] pop_data;
    logic          valid;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          error;

    fifo_ram_ctrl #(
        .AW(AW), .DW(DW), .ALMOST_FULL(6), .ALMOST_EMPTY(1)
    ) dut (
        .clk(clk), .reset(reset), .push(push), .push_data(push_data),
        .pop(pop), .ram_rdata(ram_rdata), .addrw(addrw), .addrr(addrr),
        .rw(rw), .data_in(data_in), .pop_data(pop_data), .valid(valid),
        .count(count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .error(error)
    );

    // Behavioural RAM partner
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (rw[0]) mem[addrw] <= data_in;
        if (rw[1]) ram_rdata  <= mem[addrr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model
    logic [DW-1:0] mq[$];     // FIFO contents
    logic [DW-1:0] exp_q[$];  // scoreboard: data expected on pop_data
    int            mcount = 0;
    int            mwr    = 0;
    int            mrd    = 0;
    bit            merr   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, ".count"},        32'(count),        32'(mcount));
        chk({tag, ".full"},         32'(full),         32'(mcount == DEPTH));
        chk({tag, ".empty"},        32'(empty),        32'(mcount == 0));
        chk({tag, ".almost_full"},  32'(almost_full),  32'(mcount >= 6));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(mcount <= 1));
        chk({tag, ".error"},        32'(error),        32'(merr));
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        mcount = 0; mwr = 0; mrd = 0; merr = 0;
    endtask

    // One clock cycle: drive at negedge, check command outputs, clock, check
    // registered outputs and the scoreboard.
    task automatic step(input string tag, input bit p, input logic [DW-1:0] d, input bit q);
        bit pok, qok;
        @(negedge clk);
        push = p; push_data = d; pop = q;
        pok = p && (mcount < DEPTH);
        qok = q && (mcount > 0);
        #1;
        chk({tag, ".rw"},      32'(rw),      32'({qok, pok}));
        chk({tag, ".addrw"},   32'(addrw),   32'(mwr));
        chk({tag, ".addrr"},   32'(addrr),   32'(mrd));
        chk({tag, ".data_in"}, 32'(data_in), 32'(d));
        if (qok) exp_q.push_back(mq.pop_front());
        if (pok) mq.push_back(d);
        if (pok) mwr = (mwr + 1) % DEPTH;
        if (qok) mrd = (mrd + 1) % DEPTH;
        mcount = mcount + int'(pok) - int'(qok);
        if ((p && !pok) || (q && !qok)) merr = 1;
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, 32'(valid), 32'(qok));
        if (qok) chk({tag, ".pop_data"}, 32'(pop_data), 32'(exp_q.pop_front()));
        else     chk({tag, ".pop_data0"}, 32'(pop_data), 32'(0));
        chk_status(tag);
        push = 1'b0; pop = 1'b0;
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_status("reset");
        chk("reset.rw",    32'(rw),    32'(0));
        chk("reset.addrw", 32'(addrw), 32'(0));
        chk("reset.addrr", 32'(addrr), 32'(0));
        chk("reset.valid", 32'(valid), 32'(0));
        @(negedge clk);
        reset = 1'b0;

        step("idle", 0, 4'h0, 0);

        // Fill with 1..8, then overflow
        for (int i = 1; i <= DEPTH; i++) step("fill", 1, DW'(i), 0);
        step("overflow", 1, 4'hF, 0);

        // Drain, then underflow
        for (int i = 0; i < DEPTH; i++) step("drain", 0, 4'h0, 1);
        step("underflow", 0, 4'h0, 1);

        // Simultaneous push/pop at count = 3
        for (int i = 1; i <= 3; i++) step("pre3", 1, DW'(i + 8), 0);
        step("pp_mid", 1, 4'h4, 1);
        for (int i = 0; i < 3; i++) step("drain3", 0, 4'h0, 1);

        // Simultaneous push/pop while empty
        step("pp_empty", 1, 4'hA, 1);

        // Simultaneous push/pop while full
        for (int i = 0; i < DEPTH - 1; i++) step("refill", 1, DW'(i + 2), 0);
        step("pp_full", 1, 4'h5, 1);
        for (int i = 0; i < DEPTH - 1; i++) step("drain7", 0, 4'h0, 1);

        // Reset mid-operation with a read in flight
        for (int i = 0; i < 6; i++) step("pre5", 1, DW'(i + 6), 0);
        step("pop_before_rst", 0, 4'h0, 1);
        @(negedge clk);
        pop = 1'b1;
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("midrst.count", 32'(count), 32'(0));
        chk("midrst.valid", 32'(valid), 32'(0));
        chk("midrst.addrw", 32'(addrw), 32'(0));
        chk("midrst.addrr", 32'(addrr), 32'(0));
        chk("midrst.rw",    32'(rw),    32'(0));
        @(posedge clk);
        #1;
        chk("midrst.valid_after_edge", 32'(valid), 32'(0));
        chk_status("midrst");
        @(negedge clk);
        pop = 1'b0;
        reset = 1'b0;
        step("post_push", 1, 4'h3, 0);
        step("post_pop",  0, 4'h0, 1);
        step("post_idle", 0, 4'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
